tt_lock_detector: RTL and testbench

- Lock qualification stage directly downstream of the DPLL phase-frequency detector.
- Consumes the PFD up/down pulses and the divided feedback clock.
- Judges each feedback period ("window") as good or bad, then runs a hysteresis FSM to produce a debounced lock flag, a sticky loss-of-lock flag and per-window error counts.
- Replaces the single-cycle "no up and no down" lock flop with a robust indicator.

---
 rtl/tt_lock_detector.sv | 193 +++++++++++++++++++
 tb/tb_tt_lock_detector.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_lock_detector.sv
// Lock qualification downstream of the DPLL PFD: judges each feedback window as good or bad
// and debounces the result into a lock flag, a sticky loss-of-lock flag and per-window error counts.
module tt_lock_detector #(
    parameter int ERR_TOL     = 1,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_CNT  = 2,
    parameter int WIN_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk_gen,
    input  logic             i_rst,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_clk_div,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_lock_lost,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_win_err,
    output logic             o_win_valid,
    input  logic             i_scan_en,
    input  logic             i_scan_in,
    output logic             o_scan_out
);

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2,
        LOSING    = 2'd3
    } state_t;

    localparam int TW = (WIN_TIMEOUT > 2) ? $clog2(WIN_TIMEOUT) : 1;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(WIN_TIMEOUT - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);
    localparam logic [31:0]   ERR_LIMIT = ERR_TOL;

    state_t            state;
    state_t            state_next;
    logic [GW-1:0]     good_cnt;
    logic [GW-1:0]     good_cnt_next;
    logic [BW-1:0]     bad_cnt;
    logic [BW-1:0]     bad_cnt_next;
    logic              set_lost;
    logic              locked;
    logic              locked_next;
    logic              lost;
    logic              lost_next;

    logic              prev;
    logic              started;
    logic [CNT_W-1:0]  acc;
    logic [TW-1:0]     tmo;
    logic [CNT_W-1:0]  win_err;
    logic              win_valid;

    logic              err;
    logic              fb_edge;
    logic              tmo_hit;
    logic              win_close;
    logic              win_good;
    logic [CNT_W:0]    acc_sum;
    logic [CNT_W-1:0]  acc_sat;

    // The closing cycle's own error belongs to the window it closes.
    assign err       = i_up | i_down;
    assign acc_sum   = {1'b0, acc} + {{CNT_W{1'b0}}, err};
    assign acc_sat   = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
    assign fb_edge   = i_clk_div & ~prev;
    assign tmo_hit   = (tmo == TMO_LAST) & ~fb_edge;
    assign win_close = (fb_edge & started) | tmo_hit;
    assign win_good  = fb_edge & (32'(acc_sat) <= ERR_LIMIT);

    always_ff @(posedge i_clk_gen or posedge i_rst) begin
        if (i_rst) begin
            prev      <= 1'b0;
            started   <= 1'b0;
            acc       <= '0;
            tmo       <= '0;
            win_err   <= '0;
            win_valid <= 1'b0;
        end else if (!i_scan_en) begin
            prev      <= i_clk_div;
            win_valid <= win_close;
            if (win_close) begin
                win_err <= acc_sat;
            end
            if (fb_edge | tmo_hit) begin
                acc     <= '0;
                tmo     <= '0;
                started <= 1'b1;
            end else begin
                acc <= acc_sat;
                tmo <= tmo + TW'(1);
            end
        end
    end

    // In scan mode the state bits and the lost flag form the shift chain.
    always_ff @(posedge i_clk_gen or posedge i_rst) begin
        if (i_rst) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
            lost     <= 1'b0;
        end else if (i_scan_en) begin
            state <= state_t'({state[0], i_scan_in});
            lost  <= state[1];
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            bad_cnt  <= bad_cnt_next;
            locked   <= locked_next;
            lost     <= lost_next;
        end
    end

    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        bad_cnt_next  = bad_cnt;
        set_lost      = 1'b0;
        if (win_close) begin
            case (state)
                UNLOCKED: begin
                    if (win_good) begin
                        if (LOCK_CNT == 1) begin
                            state_next = LOCKED;
                        end else begin
                            state_next    = ACQUIRING;
                            good_cnt_next = GW'(1);
                        end
                    end
                end
                ACQUIRING: begin
                    if (!win_good) begin
                        state_next    = UNLOCKED;
                        good_cnt_next = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        state_next    = LOCKED;
                        good_cnt_next = '0;
                    end else begin
                        good_cnt_next = good_cnt + GW'(1);
                    end
                end
                LOCKED: begin
                    if (!win_good) begin
                        if (UNLOCK_CNT == 1) begin
                            state_next = UNLOCKED;
                            set_lost   = 1'b1;
                        end else begin
                            state_next   = LOSING;
                            bad_cnt_next = BW'(1);
                        end
                    end
                end
                LOSING: begin
                    if (win_good) begin
                        state_next   = LOCKED;
                        bad_cnt_next = '0;
                    end else if (bad_cnt == BAD_LAST) begin
                        state_next   = UNLOCKED;
                        bad_cnt_next = '0;
                        set_lost     = 1'b1;
                    end else begin
                        bad_cnt_next = bad_cnt + BW'(1);
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                end
            endcase
        end
    end

    // A new loss overrides a simultaneous clear.
    always_comb begin
        locked_next = (state_next == LOCKED) || (state_next == LOSING);
        lost_next   = set_lost | (lost & ~i_clear);
    end

    assign o_locked    = locked;
    assign o_lock_lost = lost;
    assign o_state     = state;
    assign o_win_err   = win_err;
    assign o_win_valid = win_valid;
    assign o_scan_out  = lost;

endmodule

// File: tb/tb_tt_lock_detector.sv
// Scoreboard bench for tt_lock_detector: a behavioural model queues the expected result of every
// window close as stimulus is driven, and a negedge monitor compares it when the DUT reports.
module tb_tt_lock_detector;

    localparam int ERR_TOL     = 1;
    localparam int LOCK_CNT    = 8;
    localparam int UNLOCK_CNT  = 2;
    localparam int WIN_TIMEOUT = 64;
    localparam int CNT_W       = 8;
    localparam int SAT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             up;
    logic             down;
    logic             clk_div;
    logic             clear;
    logic             scan_en;
    logic             scan_in;

    logic             locked;
    logic             lock_lost;
    logic [1:0]       state;
    logic [CNT_W-1:0] win_err;
    logic             win_valid;
    logic             scan_out;

    logic             sat_locked;
    logic             sat_lost;
    logic [1:0]       sat_state;
    logic [CNT_W-1:0] sat_win_err;
    logic             sat_win_valid;
    logic             sat_scan_out;

    always #5 clk = ~clk;

    tt_lock_detector #(
        .ERR_TOL(ERR_TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
        .WIN_TIMEOUT(WIN_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .i_clk_gen(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_clk_div(clk_div),
        .i_clear(clear), .o_locked(locked), .o_lock_lost(lock_lost), .o_state(state),
        .o_win_err(win_err), .o_win_valid(win_valid), .i_scan_en(scan_en),
        .i_scan_in(scan_in), .o_scan_out(scan_out)
    );

    // Long timeout so a 300-cycle window can reach counter saturation.
    tt_lock_detector #(
        .ERR_TOL(ERR_TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
        .WIN_TIMEOUT(1024), .CNT_W(CNT_W)
    ) dut_sat (
        .i_clk_gen(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_clk_div(clk_div),
        .i_clear(clear), .o_locked(sat_locked), .o_lock_lost(sat_lost), .o_state(sat_state),
        .o_win_err(sat_win_err), .o_win_valid(sat_win_valid), .i_scan_en(scan_en),
        .i_scan_in(scan_in), .o_scan_out(sat_scan_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int err;
        int st;
        int lk;
        int lost;
    } exp_t;

    exp_t sbq[$];

    int m_prev, m_started, m_acc, m_tmo, m_state, m_good, m_bad, m_lost;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic resetModel();
        m_prev = 0; m_started = 0; m_acc = 0; m_tmo = 0;
        m_state = 0; m_good = 0; m_bad = 0; m_lost = 0;
        sbq.delete();
    endtask

    // Drives one cycle of inputs and advances the reference model by the same cycle.
    task automatic applyStimulus(input logic u, input logic d, input logic div, input logic clr);
        int   err;
        int   cnt;
        bit   edge_seen;
        bit   hit;
        bit   closing;
        bit   good;
        bit   setl;
        exp_t e;
        up = u; down = d; clk_div = div; clear = clr;
        err       = (u || d) ? 1 : 0;
        edge_seen = div && (m_prev == 0);
        hit       = (m_tmo == WIN_TIMEOUT - 1) && !edge_seen;
        cnt       = (m_acc + err > SAT_MAX) ? SAT_MAX : m_acc + err;
        closing   = (edge_seen && m_started != 0) || hit;
        good      = edge_seen && (cnt <= ERR_TOL);
        setl      = 0;
        if (closing) begin
            case (m_state)
                0: if (good) begin m_good = 1; m_state = 1; end
                1: if (good) m_good++; else begin m_state = 0; m_good = 0; end
                2: if (!good) begin m_bad = 1; m_state = 3; end
                default: if (!good) m_bad++; else begin m_state = 2; m_bad = 0; end
            endcase
            if (m_state == 1 && m_good >= LOCK_CNT) begin m_state = 2; m_good = 0; end
            if (m_state == 3 && m_bad >= UNLOCK_CNT) begin m_state = 0; m_bad = 0; setl = 1; end
        end
        m_lost = (setl || (m_lost != 0 && !clr)) ? 1 : 0;
        m_prev = div ? 1 : 0;
        if (edge_seen || hit) begin
            m_acc = 0; m_tmo = 0; m_started = 1;
        end else begin
            m_acc = cnt; m_tmo++;
        end
        if (closing) begin
            e.due = cyc + 1; e.err = cnt; e.st = m_state;
            e.lk = (m_state >= 2) ? 1 : 0; e.lost = m_lost;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One feedback period: errors in the first nerr cycles, rising edge in the last cycle.
    task automatic runWindow(input int len, input int nerr, input bit both, input bit clr_last);
        for (int i = 0; i < len; i++)
            applyStimulus(i < nerr, both && (i < nerr), i == len - 1, clr_last && (i == len - 1));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && !scan_en) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checkOutput("win_valid", win_valid, 1);
                checkOutput("win_err", win_err, e.err);
                checkOutput("win_state", state, e.st);
                checkOutput("win_locked", locked, e.lk);
                checkOutput("win_lost", lock_lost, e.lost);
            end else if (win_valid) begin
                checkOutput("spurious_valid", win_valid, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] ch;
        rst = 1'b1; up = 1'b0; down = 1'b0; clk_div = 1'b0;
        clear = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_lost", lock_lost, 0);
        checkOutput("rst_win_err", win_err, 0);
        checkOutput("rst_win_valid", win_valid, 0);
        checkOutput("rst_scan_out", scan_out, 0);
        checkOutput("rst_sat_outs", {sat_locked, sat_lost, sat_scan_out, sat_win_valid}, 0);
        rst = 1'b0;

        $display("[TB] clean lock");
        runWindow(10, 0, 0, 0);
        repeat (LOCK_CNT) runWindow(10, 0, 0, 0);
        checkOutput("lock_state", state, 2);
        checkOutput("lock_flag", locked, 1);

        $display("[TB] tolerance");
        runWindow(10, 1, 0, 0);
        runWindow(10, 1, 1, 0);
        checkOutput("both_err_once", win_err, 1);
        runWindow(10, 2, 0, 0);
        checkOutput("losing_state", state, 3);
        checkOutput("losing_locked", locked, 1);
        runWindow(10, 0, 0, 0);
        checkOutput("recover_state", state, 2);
        checkOutput("recover_lost", lock_lost, 0);

        $display("[TB] loss and clear");
        runWindow(10, 2, 0, 0);
        runWindow(10, 2, 0, 0);
        checkOutput("loss_locked", locked, 0);
        checkOutput("loss_lost", lock_lost, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_lost", lock_lost, 0);

        $display("[TB] set and clear together");
        repeat (LOCK_CNT) runWindow(10, 0, 0, 0);
        runWindow(10, 2, 0, 0);
        runWindow(10, 2, 0, 1);
        checkOutput("set_beats_clear", lock_lost, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_again", lock_lost, 0);

        $display("[TB] timeout");
        repeat (LOCK_CNT) runWindow(10, 0, 0, 0);
        idle(WIN_TIMEOUT - 1);
        checkOutput("tmo_not_early", win_valid, 0);
        idle(1);
        checkOutput("tmo_valid", win_valid, 1);
        checkOutput("tmo_losing", state, 3);
        idle(WIN_TIMEOUT);
        checkOutput("tmo_unlocked", state, 0);
        checkOutput("tmo_lost", lock_lost, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] saturation");
        runWindow(300, 300, 0, 0);
        checkOutput("sat_valid", sat_win_valid, 1);
        checkOutput("sat_err", sat_win_err, SAT_MAX);
        checkOutput("sat_bad_window", sat_state, 3);

        $display("[TB] scan");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        runWindow(10, 0, 0, 0);
        repeat (LOCK_CNT) runWindow(10, 0, 0, 0);
        idle(2);
        checkOutput("prescan_state", state, 2);
        checkOutput("prescan_lost", lock_lost, 0);
        ch = 3'b010;
        checkOutput("scan_out_pre", scan_out, ch[2]);
        for (int k = 0; k < 3; k++) begin
            scan_en = 1'b1; scan_in = 1'b1; up = 1'b1; clk_div = (k == 1);
            @(posedge clk);
            #1;
            ch = {ch[1:0], 1'b1};
            checkOutput("scan_out", scan_out, ch[2]);
            checkOutput("scan_state", state, ch[1:0]);
            checkOutput("scan_frozen_valid", win_valid, 0);
            checkOutput("scan_frozen_err", win_err, 0);
            checkOutput("scan_frozen_locked", locked, 1);
        end
        scan_en = 1'b0; scan_in = 1'b0; up = 1'b0; clk_div = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();

        $display("[TB] async reset mid-acquire");
        runWindow(10, 0, 0, 0);
        runWindow(10, 0, 0, 0);
        runWindow(10, 0, 0, 0);
        runWindow(10, 1, 0, 0);
        idle(2);
        checkOutput("acq_state", state, 1);
        checkOutput("acq_err", win_err, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_state", state, 0);
        checkOutput("async_locked", locked, 0);
        checkOutput("async_lost", lock_lost, 0);
        checkOutput("async_win_err", win_err, 0);
        checkOutput("async_win_valid", win_valid, 0);
        resetModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
        runWindow(10, 0, 0, 0);
        runWindow(10, 0, 0, 0);
        idle(2);
        checkOutput("post_reset_state", state, 1);

        idle(3);
        checkOutput("sb_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
